// File: rtl/serial_divider_pkg.sv
// Shared ISA definitions: operation codes and the request packets the
// serial execution units receive, each serialised LSB first.
package Isa;
  localparam int REGISTER_SIZE = 8;

  typedef enum logic [2:0] {
    ADD, SUB, LAND, LOR, LXOR, MUL, SHL, DIV
  } Operation;

  typedef struct packed {
    logic [REGISTER_SIZE-1:0] b;
    logic [REGISTER_SIZE-1:0] a;
    Operation                 op;
  } AluPacket;

  typedef struct packed {
    logic [REGISTER_SIZE-1:0] b;
    logic [REGISTER_SIZE-1:0] a;
  } MulPacket;

  typedef struct packed {
    logic [$clog2(REGISTER_SIZE)-1:0] amount;
    logic [REGISTER_SIZE-1:0]         value;
    logic                             left;
  } ShifterPacket;

  // dividend occupies the low half, so bit 0 on the wire is dividend[0]
  typedef struct packed {
    logic [REGISTER_SIZE-1:0] divisor;
    logic [REGISTER_SIZE-1:0] dividend;
  } DivPacket;
endpackage

// File: rtl/spi_if.sv
// Shared SPI bus: one select line per peripheral, miso is a shared tristate.
interface Spi #(parameter int NSS_W = 1);
  logic             sclk;
  logic [NSS_W-1:0] nss;
  logic             mosi;
  logic             miso;

  modport peripheral (input sclk, input nss, input mosi, output miso);
  modport initiator  (output sclk, output nss, output mosi, input miso);
endinterface

// File: rtl/serial_divider_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits. A zero divisor always fits, giving an all-ones quotient.
module div_step import Isa::*; #(
  parameter int W = REGISTER_SIZE
) (
  input  logic [W-1:0] remainder,
  input  logic [W-1:0] divisor,
  input  logic         dividend_bit,
  output logic [W-1:0] next_remainder,
  output logic         quotient_bit
);
  logic [W:0] trial;
  logic [W:0] diff;

  assign trial          = {remainder, dividend_bit};
  assign diff           = trial - {1'b0, divisor};
  assign quotient_bit   = (trial >= {1'b0, divisor});
  assign next_remainder = quotient_bit ? diff[W-1:0] : trial[W-1:0];
endmodule

// File: rtl/serial_divider.sv
// SPI peripheral: receives {divisor, dividend} serially, divides over W cycles,
// then answers with a one-cycle start marker followed by the quotient LSB first.
module serial_divider import Isa::*; #(
  parameter int NssPosition = 0
) (
  input  logic    i_clock,
  input  logic    i_reset,
  Spi.peripheral  spi,
  output logic    o_busy
);
  localparam int W  = REGISTER_SIZE;
  localparam int CW = $clog2(2*W);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, DIVIDE, START, SHIFT_OUT} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] step_cnt;
  DivPacket      packet;
  logic [W-1:0]  dividend_sh;
  logic [W-1:0]  remainder;
  logic [W-1:0]  quotient;
  logic          miso_q;
  logic          selected;
  logic [W-1:0]  next_rem;
  logic          q_bit;

  assign selected = ~spi.nss[NssPosition];
  assign spi.miso = selected ? miso_q : 1'bz;
  assign o_busy   = (state != IDLE);

  div_step #(.W(W)) u_step (
    .remainder      (remainder),
    .divisor        (packet.divisor),
    .dividend_bit   (dividend_sh[W-1]),
    .next_remainder (next_rem),
    .quotient_bit   (q_bit)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset || (!selected && state != IDLE)) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      step_cnt    <= '0;
      packet      <= '0;
      dividend_sh <= '0;
      remainder   <= '0;
      quotient    <= '0;
      miso_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          if (selected && spi.mosi) begin
            state   <= SHIFT_IN;
            bit_cnt <= '0;
          end
        end
        SHIFT_IN: begin
          packet[bit_cnt] <= spi.mosi;
          if (bit_cnt == CW'(2*W-1)) begin
            // dividend half is already complete when the last divisor bit lands
            state       <= DIVIDE;
            bit_cnt     <= '0;
            step_cnt    <= '0;
            dividend_sh <= packet.dividend;
            remainder   <= '0;
            quotient    <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DIVIDE: begin
          remainder   <= next_rem;
          quotient    <= {quotient[W-2:0], q_bit};
          dividend_sh <= {dividend_sh[W-2:0], 1'b0};
          if (step_cnt == CW'(W-1)) begin
            state    <= START;
            step_cnt <= '0;
            miso_q   <= 1'b1;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        START: begin
          state    <= SHIFT_OUT;
          bit_cnt  <= '0;
          miso_q   <= quotient[0];
          quotient <= quotient >> 1;
        end
        SHIFT_OUT: begin
          if (bit_cnt == CW'(W-1)) begin
            state   <= IDLE;
            bit_cnt <= '0;
            miso_q  <= 1'b0;
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            miso_q   <= quotient[0];
            quotient <= quotient >> 1;
          end
        end
        default: begin
          state  <= IDLE;
          miso_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
